// File: rtl/axi_rd_arbiter_if.sv
// ============================================================================
// Module   : axi_rd_arbiter_if
// Brief    : Bundled AR/R upstream and downstream signals of the read arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_rd_arbiter_if #(
    parameter int N_MST  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [N_MST-1:0]        s_ar_valid_i;
    logic [N_MST*ADDR_W-1:0] s_ar_addr_i;
    logic [N_MST*8-1:0]      s_ar_len_i;
    logic [N_MST*3-1:0]      s_ar_size_i;
    logic [N_MST*2-1:0]      s_ar_burst_i;
    logic [N_MST-1:0]        s_ar_ready_o;
    logic [N_MST-1:0]        s_r_valid_o;
    logic [DATA_W-1:0]       s_r_data_o;
    logic [1:0]              s_r_resp_o;
    logic                    s_r_last_o;
    logic [N_MST-1:0]        s_r_ready_i;
    logic                    m_ar_valid_o;
    logic [ADDR_W-1:0]       m_ar_addr_o;
    logic [ID_W-1:0]         m_ar_id_o;
    logic [7:0]              m_ar_len_o;
    logic [2:0]              m_ar_size_o;
    logic [1:0]              m_ar_burst_o;
    logic                    m_ar_ready_i;
    logic                    m_r_valid_i;
    logic [DATA_W-1:0]       m_r_data_i;
    logic [1:0]              m_r_resp_i;
    logic                    m_r_last_i;
    logic [ID_W-1:0]         m_r_id_i;
    logic                    m_r_ready_o;
    logic [N_MST-1:0]        grant_o;
    logic                    busy_o;

    // Arbiter side
    modport slave (
        input  s_ar_valid_i, s_ar_addr_i, s_ar_len_i, s_ar_size_i, s_ar_burst_i,
        input  s_r_ready_i, m_ar_ready_i, m_r_valid_i, m_r_data_i, m_r_resp_i,
        input  m_r_last_i, m_r_id_i,
        output s_ar_ready_o, s_r_valid_o, s_r_data_o, s_r_resp_o, s_r_last_o,
        output m_ar_valid_o, m_ar_addr_o, m_ar_id_o, m_ar_len_o, m_ar_size_o,
        output m_ar_burst_o, m_r_ready_o, grant_o, busy_o
    );

    // Environment side (upstream masters plus downstream slave)
    modport master (
        output s_ar_valid_i, s_ar_addr_i, s_ar_len_i, s_ar_size_i, s_ar_burst_i,
        output s_r_ready_i, m_ar_ready_i, m_r_valid_i, m_r_data_i, m_r_resp_i,
        output m_r_last_i, m_r_id_i,
        input  s_ar_ready_o, s_r_valid_o, s_r_data_o, s_r_resp_o, s_r_last_o,
        input  m_ar_valid_o, m_ar_addr_o, m_ar_id_o, m_ar_len_o, m_ar_size_o,
        input  m_ar_burst_o, m_r_ready_o, grant_o, busy_o
    );
endinterface

`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
// ============================================================================
// Module   : axi_rd_arbiter
// Brief    : N-master to 1-slave AXI4 read arbiter, round-robin, one txn in flight.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_rd_arbiter #(
    parameter int N_MST  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    axi_rd_arbiter_if.slave   bus
);
    localparam int c_PTR_W = (N_MST > 1) ? $clog2(N_MST) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_PTR_W-1:0]   r_last;
    logic [c_PTR_W-1:0]   r_gidx;
    logic [N_MST-1:0]     r_grant;
    logic                 r_ar_valid;
    logic [ADDR_W-1:0]    r_ar_addr;
    logic [ID_W-1:0]      r_ar_id;
    logic [7:0]           r_ar_len;
    logic [2:0]           r_ar_size;
    logic [1:0]           r_ar_burst;

    logic                 w_found;
    logic [c_PTR_W-1:0]   w_cand;
    logic [c_PTR_W-1:0]   w_win;
    logic [N_MST-1:0]     w_win_oh;
    logic                 w_ar_hs;
    logic                 w_r_done;

    // Search starts one past the last owner and wraps, giving round-robin order
    always_comb begin
        w_found = 1'b0;
        w_cand  = '0;
        w_win   = '0;
        for (int i = 0; i < N_MST; i++) begin
            w_cand = c_PTR_W'((int'(r_last) + 1 + i) % N_MST);
            if (!w_found && bus.s_ar_valid_i[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    always_comb begin
        w_win_oh = '0;
        for (int k = 0; k < N_MST; k++) begin
            w_win_oh[k] = (w_win == c_PTR_W'(k));
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_ar_hs          = 1'b0;
        w_r_done         = 1'b0;
        bus.s_ar_ready_o = '0;
        bus.s_r_valid_o  = '0;
        bus.s_r_data_o   = '0;
        bus.s_r_resp_o   = 2'b00;
        bus.s_r_last_o   = 1'b0;
        bus.m_r_ready_o  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    bus.s_ar_ready_o = w_win_oh;
                    w_ar_hs          = 1'b1;
                    w_state_nxt      = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (bus.m_ar_ready_i) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                bus.s_r_valid_o = bus.m_r_valid_i ? r_grant : '0;
                bus.m_r_ready_o = |(bus.s_r_ready_i & r_grant);
                bus.s_r_data_o  = bus.m_r_data_i;
                bus.s_r_last_o  = bus.m_r_last_i;
                // A beat tagged with someone else's ID is flagged as SLVERR
                bus.s_r_resp_o  = (bus.m_r_id_i != r_ar_id) ? 2'b10 : bus.m_r_resp_i;
                if (bus.m_r_valid_i && bus.m_r_ready_o && bus.m_r_last_i) begin
                    w_r_done    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_last     <= c_PTR_W'(N_MST - 1);
            r_gidx     <= '0;
            r_grant    <= '0;
            r_ar_valid <= 1'b0;
            r_ar_addr  <= '0;
            r_ar_id    <= '0;
            r_ar_len   <= '0;
            r_ar_size  <= '0;
            r_ar_burst <= '0;
        end else begin
            if (w_ar_hs) begin
                r_gidx     <= w_win;
                r_grant    <= w_win_oh;
                r_ar_valid <= 1'b1;
                r_ar_addr  <= bus.s_ar_addr_i[w_win*ADDR_W +: ADDR_W];
                r_ar_len   <= bus.s_ar_len_i[w_win*8 +: 8];
                r_ar_size  <= bus.s_ar_size_i[w_win*3 +: 3];
                r_ar_burst <= bus.s_ar_burst_i[w_win*2 +: 2];
                r_ar_id    <= ID_W'(w_win);
            end
            if (r_state == ST_ADDR && bus.m_ar_ready_i) begin
                r_ar_valid <= 1'b0;
            end
            if (w_r_done) begin
                r_last  <= r_gidx;
                r_grant <= '0;
            end
        end
    end

    assign bus.m_ar_valid_o = r_ar_valid;
    assign bus.m_ar_addr_o  = r_ar_addr;
    assign bus.m_ar_id_o    = r_ar_id;
    assign bus.m_ar_len_o   = r_ar_len;
    assign bus.m_ar_size_o  = r_ar_size;
    assign bus.m_ar_burst_o = r_ar_burst;
    assign bus.grant_o      = r_grant;
    assign bus.busy_o       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
// ============================================================================
// Module   : tb_axi_rd_arbiter
// Brief    : Directed self-checking bench for the round-robin AXI read arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_rd_arbiter;
    localparam int N_MST  = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    axi_rd_arbiter_if #(.N_MST(N_MST), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    axi_rd_arbiter #(.N_MST(N_MST), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) u_dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic set_req(input int k, input logic [31:0] addr, input logic [7:0] len);
        bus.s_ar_addr_i[k*ADDR_W +: ADDR_W] = addr;
        bus.s_ar_len_i[k*8 +: 8]            = len;
        bus.s_ar_size_i[k*3 +: 3]           = 3'd2;
        bus.s_ar_burst_i[k*2 +: 2]          = 2'b01;
    endtask

    task automatic beat(input logic [31:0] data, input logic last, input logic [3:0] id, input logic [1:0] resp);
        bus.m_r_valid_i = 1'b1;
        bus.m_r_data_i  = data;
        bus.m_r_last_i  = last;
        bus.m_r_id_i    = id;
        bus.m_r_resp_i  = resp;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
    endtask

    initial begin
        bus.s_ar_valid_i = '0;
        bus.s_ar_addr_i  = '0;
        bus.s_ar_len_i   = '0;
        bus.s_ar_size_i  = '0;
        bus.s_ar_burst_i = '0;
        bus.s_r_ready_i  = '0;
        bus.m_ar_ready_i = 1'b0;
        bus.m_r_valid_i  = 1'b0;
        bus.m_r_data_i   = '0;
        bus.m_r_resp_i   = 2'b00;
        bus.m_r_last_i   = 1'b0;
        bus.m_r_id_i     = '0;

        // ---------------- reset state
        do_reset();
        check("rst_busy",    64'(bus.busy_o), 64'd0);
        check("rst_grant",   64'(bus.grant_o), 64'd0);
        check("rst_arvalid", 64'(bus.m_ar_valid_o), 64'd0);
        check("rst_rready",  64'(bus.m_r_ready_o), 64'd0);

        // ---------------- single beat from master 0
        set_req(0, 32'h8000_0000, 8'd0);
        bus.s_ar_valid_i = 2'b01;
        #1 check("t1_arready_t", 64'(bus.s_ar_ready_o), 64'h1);
        tick();
        bus.s_ar_valid_i = 2'b00;
        check("t1_arvalid", 64'(bus.m_ar_valid_o), 64'd1);
        check("t1_araddr",  64'(bus.m_ar_addr_o), 64'h8000_0000);
        check("t1_arid",    64'(bus.m_ar_id_o), 64'd0);
        check("t1_grant",   64'(bus.grant_o), 64'h1);
        check("t1_arready_busy", 64'(bus.s_ar_ready_o), 64'd0);
        bus.m_ar_ready_i = 1'b1;
        tick();
        bus.m_ar_ready_i = 1'b0;
        check("t1_arvalid_drop", 64'(bus.m_ar_valid_o), 64'd0);
        bus.s_r_ready_i = 2'b01;
        beat(32'h0010_0073, 1'b1, 4'd0, 2'b01);
        #1;
        check("t1_rvalid", 64'(bus.s_r_valid_o), 64'h1);
        check("t1_rdata",  64'(bus.s_r_data_o), 64'h0010_0073);
        check("t1_rresp",  64'(bus.s_r_resp_o), 64'h1);
        check("t1_rlast",  64'(bus.s_r_last_o), 64'd1);
        check("t1_mrready", 64'(bus.m_r_ready_o), 64'd1);
        tick();
        bus.m_r_valid_i = 1'b0;
        check("t1_grant_end", 64'(bus.grant_o), 64'd0);
        check("t1_busy_end",  64'(bus.busy_o), 64'd0);

        // ---------------- fairness with both masters requesting continuously
        do_reset();
        set_req(0, 32'h0000_1000, 8'd0);
        set_req(1, 32'h0000_2000, 8'd0);
        bus.s_ar_valid_i = 2'b11;
        bus.s_r_ready_i  = 2'b11;
        #1 check("t2_first_arready", 64'(bus.s_ar_ready_o), 64'h1);
        tick();
        for (int i = 0; i < 4; i++) begin
            int exp_m;
            exp_m = i % 2;
            check("t2_arvalid", 64'(bus.m_ar_valid_o), 64'd1);
            check("t2_arid",    64'(bus.m_ar_id_o), 64'(exp_m));
            check("t2_grant",   64'(bus.grant_o), 64'(1 << exp_m));
            check("t2_araddr",  64'(bus.m_ar_addr_o), (exp_m == 0) ? 64'h1000 : 64'h2000);
            bus.m_ar_ready_i = 1'b1;
            tick();
            bus.m_ar_ready_i = 1'b0;
            beat(32'(i), 1'b1, 4'(exp_m), 2'b00);
            if (i == 3) bus.s_ar_valid_i = 2'b00;
            #1 check("t2_rvalid", 64'(bus.s_r_valid_o), 64'(1 << exp_m));
            tick();
            bus.m_r_valid_i = 1'b0;
            check("t2_gap_arvalid", 64'(bus.m_ar_valid_o), 64'd0);
            check("t2_gap_busy",    64'(bus.busy_o), 64'd0);
            if (i < 3) begin
                check("t2_gap_arready", 64'(bus.s_ar_ready_o), 64'(1 << (1 - exp_m)));
                tick();
            end
        end

        // ---------------- master 1 burst of 4 with an upstream stall on beat 2
        set_req(1, 32'h0000_3000, 8'd3);
        bus.s_ar_valid_i = 2'b10;
        bus.s_r_ready_i  = 2'b10;
        tick();
        bus.s_ar_valid_i = 2'b00;
        check("t3_arlen", 64'(bus.m_ar_len_o), 64'd3);
        check("t3_arid",  64'(bus.m_ar_id_o), 64'd1);
        bus.m_ar_ready_i = 1'b1;
        tick();
        bus.m_ar_ready_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            beat(32'hA0 + 32'(b), (b == 3), 4'd1, 2'b00);
            if (b == 2) begin
                bus.s_r_ready_i = 2'b00;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    check("t3_stall_mrready", 64'(bus.m_r_ready_o), 64'd0);
                    check("t3_stall_rvalid",  64'(bus.s_r_valid_o), 64'h2);
                    tick();
                end
                bus.s_r_ready_i = 2'b10;
            end
            #1;
            check("t3_mrready", 64'(bus.m_r_ready_o), 64'd1);
            check("t3_rdata",   64'(bus.s_r_data_o), 64'hA0 + 64'(b));
            check("t3_busy",    64'(bus.busy_o), 64'd1);
            tick();
        end
        bus.m_r_valid_i = 1'b0;
        check("t3_busy_end",  64'(bus.busy_o), 64'd0);
        check("t3_grant_end", 64'(bus.grant_o), 64'd0);

        // ---------------- AR back-pressure for 5 cycles, master 0 competing
        set_req(1, 32'h0000_4000, 8'd2);
        set_req(0, 32'h0000_5000, 8'd0);
        bus.s_ar_valid_i = 2'b10;
        bus.s_r_ready_i  = 2'b11;
        tick();
        bus.s_ar_valid_i = 2'b11;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("t4_arvalid", 64'(bus.m_ar_valid_o), 64'd1);
            check("t4_araddr",  64'(bus.m_ar_addr_o), 64'h4000);
            check("t4_arlen",   64'(bus.m_ar_len_o), 64'd2);
            check("t4_arid",    64'(bus.m_ar_id_o), 64'd1);
            check("t4_arready", 64'(bus.s_ar_ready_o), 64'd0);
            tick();
        end
        bus.m_ar_ready_i = 1'b1;
        tick();
        bus.m_ar_ready_i = 1'b0;
        beat(32'h44, 1'b1, 4'd1, 2'b00);
        bus.s_ar_valid_i = 2'b01;
        tick();
        bus.m_r_valid_i = 1'b0;
        #1 check("t4_next_arready", 64'(bus.s_ar_ready_o), 64'h1);

        // ---------------- reset in the middle of a DATA phase
        tick();
        bus.s_ar_valid_i = 2'b00;
        check("t5_grant", 64'(bus.grant_o), 64'h1);
        check("t5_araddr", 64'(bus.m_ar_addr_o), 64'h5000);
        bus.m_ar_ready_i = 1'b1;
        tick();
        bus.m_ar_ready_i = 1'b0;
        beat(32'h55, 1'b0, 4'd0, 2'b00);
        #1 check("t5_rvalid", 64'(bus.s_r_valid_o), 64'h1);
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        #1;
        check("t5_rst_arvalid", 64'(bus.m_ar_valid_o), 64'd0);
        check("t5_rst_grant",   64'(bus.grant_o), 64'd0);
        check("t5_rst_busy",    64'(bus.busy_o), 64'd0);
        check("t5_rst_rvalid",  64'(bus.s_r_valid_o), 64'd0);
        check("t5_rst_mrready", 64'(bus.m_r_ready_o), 64'd0);
        check("t5_rst_rdata",   64'(bus.s_r_data_o), 64'd0);
        check("t5_rst_araddr",  64'(bus.m_ar_addr_o), 64'd0);
        check("t5_rst_arlen",   64'(bus.m_ar_len_o), 64'd0);
        check("t5_rst_arready", 64'(bus.s_ar_ready_o), 64'd0);
        bus.m_r_valid_i  = 1'b0;
        bus.s_ar_valid_i = 2'b11;
        #1 check("t5_first_arready", 64'(bus.s_ar_ready_o), 64'h1);
        tick();
        bus.s_ar_valid_i = 2'b00;
        check("t5_first_grant", 64'(bus.grant_o), 64'h1);
        check("t5_first_arid",  64'(bus.m_ar_id_o), 64'd0);
        bus.m_ar_ready_i = 1'b1;
        tick();
        bus.m_ar_ready_i = 1'b0;
        beat(32'h66, 1'b1, 4'd0, 2'b00);
        tick();
        bus.m_r_valid_i = 1'b0;

        // ---------------- RID mismatch turns response into SLVERR
        set_req(1, 32'h0000_6000, 8'd0);
        bus.s_ar_valid_i = 2'b10;
        tick();
        bus.s_ar_valid_i = 2'b00;
        check("t6_arid", 64'(bus.m_ar_id_o), 64'd1);
        bus.m_ar_ready_i = 1'b1;
        tick();
        bus.m_ar_ready_i = 1'b0;
        beat(32'hDEAD_BEEF, 1'b1, 4'd0, 2'b00);
        #1;
        check("t6_rresp",  64'(bus.s_r_resp_o), 64'h2);
        check("t6_rdata",  64'(bus.s_r_data_o), 64'hDEAD_BEEF);
        check("t6_rvalid", 64'(bus.s_r_valid_o), 64'h2);
        tick();
        bus.m_r_valid_i = 1'b0;
        check("t6_busy_end", 64'(bus.busy_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- N-master, 1-slave AXI4 read-channel arbiter with round-robin grant.
- Lets IFU, LSU and later DMA share the single io_master AR/R port of the core.
- Supersedes the fixed single-master IFU fetch path: channel count, address/data/ID widths and burst length are parametrised.
- One transaction in flight at a time. The grant is held from AR acceptance until the R beat carrying rlast.

Parameters:
- N_MST, 2, number of upstream read masters (>=1).
- ADDR_W, 32, address width.
- DATA_W, 32, read data width.
- ID_W, 4, downstream ARID/RID width (>= clog2(N_MST), minimum 1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-low.
- s_ar_valid_i  in  N_MST  per-master AR valid.
- s_ar_addr_i  in  N_MST*ADDR_W  per-master address; master k at slice [k*ADDR_W +: ADDR_W].
- s_ar_len_i  in  N_MST*8  per-master ARLEN.
- s_ar_size_i  in  N_MST*3  per-master ARSIZE.
- s_ar_burst_i  in  N_MST*2  per-master ARBURST.
- s_ar_ready_o  out  N_MST  per-master AR ready.
- s_r_valid_o  out  N_MST  per-master R valid.
- s_r_data_o  out  DATA_W  R data, broadcast to all masters.
- s_r_resp_o  out  2  R resp, broadcast.
- s_r_last_o  out  1  R last, broadcast.
- s_r_ready_i  in  N_MST  per-master R ready.
- m_ar_valid_o  out  1  downstream AR valid.
- m_ar_addr_o  out  ADDR_W  downstream AR address.
- m_ar_id_o  out  ID_W  downstream AR ID = granted index, zero-extended.
- m_ar_len_o  out  8  downstream ARLEN.
- m_ar_size_o  out  3  downstream ARSIZE.
- m_ar_burst_o  out  2  downstream ARBURST.
- m_ar_ready_i  in  1  downstream AR ready.
- m_r_valid_i  in  1  downstream R valid.
- m_r_data_i  in  DATA_W  downstream R data.
- m_r_resp_i  in  2  downstream R resp.
- m_r_last_i  in  1  downstream R last.
- m_r_id_i  in  ID_W  downstream R ID.
- m_r_ready_o  out  1  downstream R ready.
- grant_o  out  N_MST  one-hot current owner; 0 when idle.
- busy_o  out  1  high in ADDR or DATA.

Behaviour:
- Reset (rst_i=0 at a clock edge):
  - FSM to IDLE.
  - All outputs 0, including registered m_ar_* fields.
  - Round-robin pointer last = N_MST-1, so master 0 has first priority.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - Winner g = first k with s_ar_valid_i[k]=1, searching (last+1) mod N_MST upward with wrap.
  - s_ar_ready_o[g]=1 for the winner only, same cycle (combinational). This is the upstream AR handshake.
  - On that edge: latch addr/len/size/burst of g into the m_ar_* registers, m_ar_id_o<=g, grant<=onehot(g), go to ADDR.
  - No valid request: stay in IDLE, all ready outputs 0.
- ADDR:
  - m_ar_valid_o=1; all fields stable until the handshake.
  - m_ar_valid_o does not depend on m_ar_ready_i.
  - On m_ar_ready_i=1: m_ar_valid_o<=0, go to DATA.
- DATA:
  - s_r_valid_o[g]=m_r_valid_i; all other bits 0.
  - m_r_ready_o = s_r_ready_i[g].
  - s_r_data_o = m_r_data_i; s_r_last_o = m_r_last_i.
  - s_r_resp_o = m_r_resp_i, except 2'b10 (SLVERR) when m_r_id_i != m_ar_id_o.
  - On beat handshake with m_r_last_i=1: last<=g, grant<=0, go to IDLE.
  - Beats without m_r_last_i are forwarded and the state does not change. No beat counting; rlast is authoritative.
- Outside DATA: m_r_ready_o=0 and all s_r_valid_o=0. Stray R beats are stalled, not dropped.
- s_ar_ready_o = 0 in ADDR and DATA. New requests wait; masters must hold valid per AXI.
- Latency:
  - Upstream AR accept at cycle t; m_ar_valid_o high from t+1.
  - Zero added latency on R (combinational pass-through).
  - One IDLE cycle between rlast and the next grant.
- Fairness: with all masters requesting continuously, grants rotate 0,1,...,N_MST-1,0. No master waits more than N_MST-1 transactions.
- N_MST=1: pointer logic degenerates; master 0 is always granted; otherwise identical behaviour.
- Reset mid-transaction: the in-flight transaction is abandoned, with no flush or drain. The integrator must reset the downstream slave together with this block.
- Downstream lowering m_ar_valid before ready, or ID violations: not checked beyond the RID-mismatch SLVERR.

Test Plan:
- Master 0 requests addr 0x8000_0000 len 0; m_ar_ready_i=1; one R beat 0x0010_0073 with last -> s_ar_ready_o[0] at t, m_ar_valid_o at t+1 with id 0, s_r_valid_o=2'b01, data 0x0010_0073, grant_o back to 0.
- Masters 0 and 1 request simultaneously and continuously, N_MST=2 -> grant order 0,1,0,1. m_ar_id_o alternates 0,1. Exactly one idle cycle between each rlast and the next m_ar_valid_o.
- Master 1 burst len 3; s_r_ready_i[1] low on beat 2 for 3 cycles -> m_r_ready_o mirrors it; 4 beats delivered in order; return to IDLE only after the beat with last.
- m_ar_ready_i held low 5 cycles -> m_ar_valid_o and addr/len/id stable all 5 cycles; s_ar_ready_o stays 0 for a competing master 0 request.
- Burst in DATA state, rst_i=0 for one cycle -> next cycle all outputs 0, state IDLE. First grant after reset goes to master 0 even when master 1 also requests.
- Granted id 1 while downstream returns m_r_id_i=0 with resp 2'b00 -> s_r_resp_o=2'b10; data still forwarded.
